// File: rtl/painter_pll_sup_pkg.sv
// painter_pll_sup_pkg: shared types for the PLL supervisor.
// Holds the FSM state enum, domain count and a zero-guard helper.
package painter_pll_sup_pkg;

  localparam int NUM_DOMAINS = 4;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  // A zero cycle count is meaningless; treat it as one cycle.
  function automatic int unsigned nz(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/painter_sync2.sv
// painter_sync2: 1-bit two-flop synchronizer, sync active-high reset to 0.
// Ports: clk, rst, d (async input), q (synchronized output).
module painter_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1 <= 1'b0;
      q   <= 1'b0;
    end else begin
      ff1 <= d;
      q   <= ff1;
    end
  end

endmodule

// File: rtl/painter_pll_supervisor.sv
// painter_pll_supervisor: PLL reset sequencer and per-domain reset release.
// Ports: refclk (clock), rst (sync, active-high), locked (async PLL lock),
//   pll_rst (PLL reset), rst_out[3:0] (domain resets), ready,
//   relock_count (lock losses seen in RUN, saturating).
// Option: PAINTER_PLL_SUP_TIMEOUT_EN re-resets the PLL if lock never comes.
module painter_pll_supervisor
  import painter_pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 8,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RELEASE_GAP_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic [7:0]             relock_count
);

  localparam int unsigned P  = nz(PLL_RST_CYCLES);
  localparam int unsigned S  = nz(LOCK_STABLE_CYCLES);
  localparam int unsigned G  = nz(RELEASE_GAP_CYCLES);
  localparam int unsigned RL = (NUM_DOMAINS - 1) * G;

  localparam int PW  = $clog2(P + 1);
  localparam int SW  = $clog2(S + 1);
  localparam int RW  = $clog2(RL + 1);
  localparam int CW0 = (PW > SW) ? PW : SW;
  localparam int CW  = (CW0 > RW) ? CW0 : RW;

  localparam logic [CW-1:0] P_END = CW'(P - 1);
  localparam logic [CW-1:0] S_END = CW'(S - 1);
  localparam logic [CW-1:0] R_END = CW'(RL);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [7:0]      relock_n;
  logic            locked_s;

  painter_sync2 u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

`ifdef PAINTER_PLL_SUP_TIMEOUT_EN
  localparam int unsigned T  = nz(LOCK_TIMEOUT_CYCLES);
  localparam int          TW = $clog2(T + 1);
  localparam logic [TW-1:0] T_END = TW'(T - 1);

  logic [TW-1:0] tcnt, tcnt_n;

  always_ff @(posedge refclk) begin
    if (rst) tcnt <= '0;
    else     tcnt <= tcnt_n;
  end
`endif

  always_ff @(posedge refclk) begin
    if (rst) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      relock_count <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      relock_count <= relock_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    relock_n = relock_count;
    pll_rst  = 1'b0;
    rst_out  = '1;
    ready    = 1'b0;
`ifdef PAINTER_PLL_SUP_TIMEOUT_EN
    // Cleared outside WAIT_LOCK, so every entry starts from zero.
    tcnt_n   = '0;
`endif
    unique case (state)
      PLL_RESET: begin
        pll_rst = 1'b1;
        if (cnt == P_END) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end
`ifdef PAINTER_PLL_SUP_TIMEOUT_EN
        else if (tcnt == T_END) begin
          state_n = PLL_RESET;
          cnt_n   = '0;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
`endif
      end
      STABLE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == S_END) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          state_n = PLL_RESET;
          cnt_n   = '0;
        end else begin
          // Domain i is released once i gaps have elapsed.
          for (int i = 0; i < NUM_DOMAINS; i++)
            rst_out[i] = (cnt < CW'(i * G));
          if (cnt == R_END) state_n = RUN;
          else              cnt_n   = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_n = PLL_RESET;
          cnt_n   = '0;
          if (relock_count != 8'hFF)
            relock_n = relock_count + 1'b1;
        end else begin
          rst_out = '0;
          ready   = 1'b1;
        end
      end
      default: begin
        state_n = PLL_RESET;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_painter_pll_supervisor.sv
// tb_painter_pll_supervisor: scoreboard bench for the PLL supervisor.
// Model predicts all outputs per cycle; monitor compares on negedge.
module tb_painter_pll_supervisor;

  localparam int P = 3;
  localparam int S = 8;
  localparam int G = 4;
  localparam int T = 32;
`ifdef PAINTER_PLL_SUP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic [3:0] rst_out;
  logic       ready;
  logic [7:0] relock_count;

  painter_pll_supervisor #(
    .PLL_RST_CYCLES      (P),
    .LOCK_STABLE_CYCLES  (S),
    .RELEASE_GAP_CYCLES  (G),
    .LOCK_TIMEOUT_CYCLES (T)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .rst_out      (rst_out),
    .ready        (ready),
    .relock_count (relock_count)
  );

  always #5 refclk = ~refclk;

  typedef enum int {M_PR, M_WAIT, M_STAB, M_REL, M_RUN} mph_t;

  mph_t        m_ph  = M_PR;
  int          m_t   = 0;
  int          m_cnt = 0;
  bit          s1    = 1'b0;
  bit          s2    = 1'b0;
  logic [13:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [13:0] predict();
    logic       p;
    logic [3:0] ro;
    logic       rd;
    p  = (m_ph == M_PR);
    ro = 4'hF;
    rd = 1'b0;
    if (m_ph == M_REL && s2)
      ro = 4'(15 & ~((1 << (m_t / G + 1)) - 1));
    if (m_ph == M_RUN && s2) begin
      ro = 4'h0;
      rd = 1'b1;
    end
    return {p, ro, rd, 8'(m_cnt)};
  endfunction

  // Reference model: phase + time-in-phase, lock seen two edges late.
  initial begin : model
    bit ls;
    forever begin
      @(posedge refclk);
      if (rst) begin
        m_ph = M_PR; m_t = 0; m_cnt = 0; s1 = 0; s2 = 0;
      end else begin
        ls = s2;
        case (m_ph)
          M_PR: begin
            m_t++;
            if (m_t == P) begin m_ph = M_WAIT; m_t = 0; end
          end
          M_WAIT: begin
            if (ls) begin
              m_ph = M_STAB; m_t = 0;
            end else if (TO_EN) begin
              m_t++;
              if (m_t == T) begin m_ph = M_PR; m_t = 0; end
            end
          end
          M_STAB: begin
            if (!ls) begin
              m_ph = M_WAIT; m_t = 0;
            end else begin
              m_t++;
              if (m_t == S) begin m_ph = M_REL; m_t = 0; end
            end
          end
          M_REL: begin
            if (!ls) begin m_ph = M_PR; m_t = 0; end
            else if (m_t == 3 * G) m_ph = M_RUN;
            else m_t++;
          end
          M_RUN: begin
            if (!ls) begin
              m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
              m_ph  = M_PR;
              m_t   = 0;
            end
          end
          default: m_ph = M_PR;
        endcase
        s2 = s1;
        s1 = locked;
      end
      exp_q.push_back(predict());
    end
  end

  initial begin : monitor
    logic [13:0] e;
    logic [13:0] a;
    forever begin
      @(negedge refclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pll_rst, rst_out, ready, relock_count};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL out t=%0t got pll=%b ro=%h rdy=%b rc=%0d want pll=%b ro=%h rdy=%b rc=%0d",
                   $time, a[13], a[12:9], a[8], a[7:0],
                   e[13], e[12:9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic l, input int n);
    rst    = r;
    locked = l;
    repeat (n) begin
      @(posedge refclk);
      #3;
    end
  endtask

  task automatic wait_model(input mph_t ph, input int t, input int bound);
    int k = 0;
    while (!(m_ph == ph && m_t == t) && k < bound) begin
      @(posedge refclk);
      #3;
      k++;
    end
    if (k >= bound) begin
      total++;
      bad++;
      $display("FAIL wait_model ph=%0d t=%0d got ph=%0d t=%0d", ph, t, m_ph, m_t);
    end
  endtask

  initial begin : driver
    cyc(1, 0, 2);
    // release with lock held
    cyc(0, 1, 40);
    // loss in RUN
    cyc(0, 0, 1);
    cyc(0, 1, 40);
    // glitch during STABLE
    cyc(1, 0, 1);
    cyc(0, 1, 1);
    wait_model(M_STAB, 5, 100);
    cyc(0, 0, 1);
    cyc(0, 1, 40);
    // lock held low: timeout behaviour
    cyc(0, 0, 100);
    // random traffic
    repeat (80) begin
      cyc(logic'($urandom_range(0, 24) == 0),
          logic'($urandom_range(0, 3) != 0),
          int'($urandom_range(1, 40)));
    end
    // saturation
    cyc(1, 0, 1);
    repeat (300) begin
      cyc(0, 1, 40);
      cyc(0, 0, 2);
    end
    cyc(0, 1, 40);
    @(negedge refclk);
    #1;
    total++;
    if (relock_count !== 8'd255) begin
      bad++;
      $display("FAIL sat got=%0d want=255", relock_count);
    end
    // rst in the middle of RELEASE
    cyc(0, 0, 2);
    cyc(0, 1, 1);
    wait_model(M_REL, 5, 200);
    cyc(1, 1, 1);
    cyc(0, 1, 10);
    @(negedge refclk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
